key_debounce_bank: RTL and testbench

Parametrised multi-channel key front end: synchronises, debounces and classifies N asynchronous push-button inputs into clean levels and single-cycle press, release, long-press and auto-repeat events. It sits between the board button pins and the menu/state logic of the display designs. It replaces the single-button, release-only debounce used in earlier test tops. Every channel is independent and identical.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce_ch.sv | 198 +++++++++++++++++++
 rtl/key_debounce_bank.sv | 61 ++++++
 tb/tb_key_debounce_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key_debounce_bank slice.
//   key_state_e  - per-channel key FSM state
//   ms_to_cycles - converts a millisecond time to clk cycles at a given clk rate
package key_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } key_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel (2-flop synchroniser, debounce/classify FSM,
// debounce, hold and repeat counters). All outputs are registered.
// Optional feature macro: KEY_REPEAT_EN (builds the repeat counter; otherwise
// repeat_o is tied low and LONG_HELD only waits for release).
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous, active-high
//   key_i     in  raw asynchronous key pin
//   level_o   out debounced level, 1 = pressed
//   press_o   out 1-cycle pulse on accepted press
//   release_o out 1-cycle pulse on accepted release
//   long_o    out 1-cycle pulse once per press after LONG_CYC held
//   repeat_o  out 1-cycle pulse every REPEAT_CYC after long_o while held
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC    = 1,
  parameter int unsigned LONG_CYC   = 1,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REPEAT_CYC = 1,
`endif
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
  localparam int unsigned LONG_W = $clog2(LONG_CYC + 1);
  localparam logic        REL_LVL = ACTIVE_LOW;

  logic              sync1_q, sync2_q;
  logic              pressed;
  key_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              was_long_q, was_long_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYC + 1);
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              repeat_q, repeat_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    was_long_d = was_long_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d      = rep_q;
    repeat_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = DEB_PRESS;
          deb_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
          state_d    = HELD;
          deb_d      = '0;
          hold_d     = '0;
          was_long_d = 1'b0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = DEB_RELEASE;
          deb_d   = '0;
        end else if (hold_q == LONG_W'(LONG_CYC - 1)) begin
          state_d    = LONG_HELD;
          was_long_d = 1'b1;
          long_d     = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_d      = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!pressed) begin
          state_d = DEB_RELEASE;
          deb_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_q == REP_W'(REPEAT_CYC - 1)) begin
          rep_d    = '0;
          repeat_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      DEB_RELEASE: begin
        // Bounce back to whichever held state we came from; hold/repeat
        // counters were left untouched so they simply resume.
        if (pressed) begin
          state_d = was_long_q ? LONG_HELD : HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
          state_d    = IDLE;
          deb_d      = '0;
          hold_d     = '0;
          was_long_d = 1'b0;
          level_d    = 1'b0;
          release_d  = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      deb_q      <= '0;
      hold_q     <= '0;
      was_long_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      was_long_q <= was_long_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: N_KEYS independent key channels that synchronise,
// debounce and classify raw button pins into levels and 1-cycle events.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat events after key_long).
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-high
//   key_in       in  [N_KEYS] raw button pins, asynchronous
//   key_level    out [N_KEYS] debounced level, 1 = pressed
//   key_press    out [N_KEYS] 1-cycle pulse on accepted press
//   key_release  out [N_KEYS] 1-cycle pulse on accepted release
//   key_long     out [N_KEYS] 1-cycle pulse once per press after LONG_MS held
//   key_repeat   out [N_KEYS] 1-cycle pulse every REPEAT_MS after key_long
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 5,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned DEB_CYC    = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC   = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned REPEAT_CYC = ms_to_cycles(CLK_HZ, REPEAT_MS);

  if (DEB_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("key_debounce_bank: every cycle constant must be at least 1");
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
`ifdef KEY_REPEAT_EN
      .REPEAT_CYC (REPEAT_CYC),
`endif
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .key_i     (key_in[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g]),
      .long_o    (key_long[g]),
      .repeat_o  (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: stimulus pushes expected events,
// a negedge monitor pops and compares whenever any event pulse is seen.
module tb_key_debounce_bank;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_a = 5'b11111;
  logic [4:0] key_b = 5'b11111;
  logic [4:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
  logic [4:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;

  typedef struct {
    int         cyc;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] lng;
    logic [4:0] rpt;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t ea, eb;
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  int  t0, t1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_bank #(
    .N_KEYS(5), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5),
    .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .key_in(key_a), .key_level(lvl_a),
    .key_press(prs_a), .key_release(rel_a), .key_long(lng_a), .key_repeat(rpt_a)
  );

  key_debounce_bank #(
    .N_KEYS(5), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5),
    .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .key_in(key_b), .key_level(lvl_b),
    .key_press(prs_b), .key_release(rel_b), .key_long(lng_b), .key_repeat(rpt_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %b, expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input ev_t e, input logic [4:0] p,
                        input logic [4:0] r, input logic [4:0] l, input logic [4:0] t);
    n_chk++;
    if (e.cyc != cyc || e.prs !== p || e.rel !== r || e.lng !== l || e.rpt !== t) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d press=%b rel=%b long=%b rpt=%b, expected cyc=%0d press=%b rel=%b long=%b rpt=%b",
               name, cyc, p, r, l, t, e.cyc, e.prs, e.rel, e.lng, e.rpt);
    end
  endtask

  task automatic push_a(input int c, input logic [4:0] p, input logic [4:0] r,
                        input logic [4:0] l, input logic [4:0] t);
    q_a.push_back('{cyc: c, prs: p, rel: r, lng: l, rpt: t});
  endtask

  task automatic push_b(input int c, input logic [4:0] p, input logic [4:0] r,
                        input logic [4:0] l, input logic [4:0] t);
    q_b.push_back('{cyc: c, prs: p, rel: r, lng: l, rpt: t});
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  // Monitor: any event pulse pops the next expected event.
  always @(negedge clk) begin
    if (|{prs_a, rel_a, lng_a, rpt_a}) begin
      if (q_a.size() == 0) ea = '{cyc: -1, prs: '0, rel: '0, lng: '0, rpt: '0};
      else ea = q_a.pop_front();
      cmp_ev("event_a", ea, prs_a, rel_a, lng_a, rpt_a);
    end
    if (|{prs_b, rel_b, lng_b, rpt_b}) begin
      if (q_b.size() == 0) eb = '{cyc: -1, prs: '0, rel: '0, lng: '0, rpt: '0};
      else eb = q_b.pop_front();
      cmp_ev("event_b", eb, prs_b, rel_b, lng_b, rpt_b);
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: test did not complete, cyc=%0d", cyc);
    summary();
    $finish;
  end

  initial begin
    // Reset with all keys pressed on the active-high bank.
    @(negedge clk); @(negedge clk);
    chk("reset_out_a", {lvl_a, prs_a, rel_a, lng_a, rpt_a}, '0);
    chk("reset_out_b", {lvl_b, prs_b, rel_b, lng_b, rpt_b}, '0);
    t0 = cyc + 1;
    reset = 1'b0;
    push_a(t0 + 6, 5'b11111, '0, '0, '0);
    push_a(t0 + 16, '0, 5'b11111, '0, '0);
    go(t0 + 5);  chk("rst_lvl_pre", lvl_a, 5'b00000);
    go(t0 + 6);  chk("rst_lvl_on", lvl_a, 5'b11111);
    go(t0 + 9);  key_a = '0;
    go(t0 + 15); chk("rst_lvl_hold", lvl_a, 5'b11111);
    go(t0 + 16); chk("rst_lvl_off", lvl_a, 5'b00000);
    go(t0 + 25);

    // Key 0: press 0..11, release at 12.
    t0 = cyc + 1;
    key_a[0] = 1'b1;
    push_a(t0 + 6, 5'b00001, '0, '0, '0);
    push_a(t0 + 18, '0, 5'b00001, '0, '0);
    go(t0 + 5);  chk("k0_lvl_pre", lvl_a, 5'b00000);
    go(t0 + 6);  chk("k0_lvl_on", lvl_a, 5'b00001);
    go(t0 + 11); key_a[0] = 1'b0;
    go(t0 + 17); chk("k0_lvl_last", lvl_a, 5'b00001);
    go(t0 + 18); chk("k0_lvl_off", lvl_a, 5'b00000);
    go(t0 + 28);

    // Key 1: 3-cycle high glitch, then hold with a 3-cycle low dip.
    t0 = cyc + 1;
    key_a[1] = 1'b1;
    go(t0 + 2);  key_a[1] = 1'b0;
    go(t0 + 10); chk("k1_glitch_lvl", lvl_a, 5'b00000);
    t1 = cyc + 1;
    key_a[1] = 1'b1;
    push_a(t1 + 6, 5'b00010, '0, '0, '0);
    push_a(t1 + 22, '0, 5'b00010, '0, '0);
    go(t1 + 9);  key_a[1] = 1'b0;
    go(t1 + 12); key_a[1] = 1'b1;
    go(t1 + 13); chk("k1_dip_lvl", lvl_a, 5'b00010);
    go(t1 + 15); key_a[1] = 1'b0;
    go(t1 + 17); chk("k1_after_dip", lvl_a, 5'b00010);
    go(t1 + 21); chk("k1_lvl_last", lvl_a, 5'b00010);
    go(t1 + 22); chk("k1_lvl_off", lvl_a, 5'b00000);
    go(t1 + 30);

    // Key 2: held 40 cycles -> long press and auto-repeat.
    t0 = cyc + 1;
    key_a[2] = 1'b1;
    push_a(t0 + 6, 5'b00100, '0, '0, '0);
    push_a(t0 + 26, '0, '0, 5'b00100, '0);
`ifdef KEY_REPEAT_EN
    push_a(t0 + 31, '0, '0, '0, 5'b00100);
    push_a(t0 + 36, '0, '0, '0, 5'b00100);
    push_a(t0 + 41, '0, '0, '0, 5'b00100);
`endif
    push_a(t0 + 46, '0, 5'b00100, '0, '0);
    go(t0 + 26); chk("k2_lvl_long", lvl_a, 5'b00100);
    go(t0 + 39); key_a[2] = 1'b0;
    go(t0 + 45); chk("k2_lvl_last", lvl_a, 5'b00100);
    go(t0 + 46); chk("k2_lvl_off", lvl_a, 5'b00000);
    go(t0 + 55);

    // Active-low bank: keys 0 and 4 pressed together.
    t0 = cyc + 1;
    key_b = 5'b01110;
    push_b(t0 + 6, 5'b10001, '0, '0, '0);
    push_b(t0 + 14, '0, 5'b10001, '0, '0);
    go(t0 + 6);  chk("al_lvl_on", lvl_b, 5'b10001);
    go(t0 + 7);  key_b = 5'b11111;
    go(t0 + 14); chk("al_lvl_off", lvl_b, 5'b00000);
    chk("al_bank_a_quiet", lvl_a, 5'b00000);
    go(t0 + 22);

    // Key 3: reset pulsed mid-hold, key kept pressed.
    t0 = cyc + 1;
    key_a[3] = 1'b1;
    push_a(t0 + 6, 5'b01000, '0, '0, '0);
    go(t0 + 14); chk("k3_lvl_pre_rst", lvl_a, 5'b01000);
    reset = 1'b1;
    #1;
    chk("k3_rst_async", {lvl_a, prs_a, rel_a, lng_a, rpt_a}, '0);
    go(t0 + 16);
    t1 = cyc + 1;
    reset = 1'b0;
    push_a(t1 + 6, 5'b01000, '0, '0, '0);
    push_a(t1 + 16, '0, 5'b01000, '0, '0);
    go(t1 + 5);  chk("k3_lvl_pre", lvl_a, 5'b00000);
    go(t1 + 6);  chk("k3_lvl_on", lvl_a, 5'b01000);
    go(t1 + 9);  key_a[3] = 1'b0;
    go(t1 + 16); chk("k3_lvl_off", lvl_a, 5'b00000);
    go(t1 + 26);

    chk("queue_a_left", q_a.size(), 0);
    chk("queue_b_left", q_b.size(), 0);
    summary();
    $finish;
  end

endmodule
